// File: rtl/instr_fetch_unit.sv
// In-order instruction fetch: credit-limited imem reads, response FIFO, decode handshake.
// Optional FETCH_STATS_EN adds fetchCount/flushCount pop and redirect counters.
module instr_fetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirectPc,
  output logic              imemReqValid,
  input  logic              imemReqReady,
  output logic [ADDR_W-1:0] imemReqAddr,
  input  logic              imemRspValid,
  input  logic [DATA_W-1:0] imemRspData,
  output logic              instrValid,
  input  logic              instrReady,
  output logic [DATA_W-1:0] instrData,
  output logic [ADDR_W-1:0] instrPc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       fetchCount,
  output logic [31:0]       flushCount
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]   DEPTH_U = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  typedef enum logic {FETCH, FLUSH} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } fetch_entry_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [CNT_W:0]    stale;

  fetch_entry_t      fifo_mem [FIFO_DEPTH];
  fetch_entry_t      head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W:0]    used;
  logic              req_fire, push, pop;
  logic [ADDR_W-1:0] redirect_pc_al;

  // Outstanding reads plus buffered entries never exceed FIFO_DEPTH, so a push always has room.
  assign used         = {1'b0, fifo_cnt} + {1'b0, inflight_q};
  assign imemReqValid = rstN && (state_q == FETCH) && !redirect && (used < DEPTH_U);
  assign imemReqAddr  = fetch_pc_q;
  assign req_fire     = imemReqValid && imemReqReady;
  assign push         = imemRspValid && (state_q == FETCH) && !redirect;
  assign pop          = (fifo_cnt != '0) && instrReady && !redirect;
  assign redirect_pc_al = redirectPc & ALIGN_MASK;

  assign head       = fifo_mem[rd_ptr];
  assign instrValid = (fifo_cnt != '0);
  assign instrData  = instrValid ? head.data : '0;
  assign instrPc    = instrValid ? head.pc   : '0;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    stale      = {1'b0, drop_q} + {1'b0, inflight_q};
    if (redirect) begin
      // Everything not yet returned becomes stale; a response landing now is already gone.
      if (imemRspValid && (stale != '0)) stale = stale - (CNT_W+1)'(1);
      drop_d     = stale[CNT_W-1:0];
      inflight_d = '0;
      fetch_pc_d = redirect_pc_al;
      rsp_pc_d   = redirect_pc_al;
      state_d    = (stale != '0) ? FLUSH : FETCH;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_INC;
      case (state_q)
        FETCH: begin
          if (push) rsp_pc_d = rsp_pc_q + PC_INC;
          if (req_fire && !push)
            inflight_d = inflight_q + CNT_ONE;
          else if (!req_fire && push && (inflight_q != '0))
            inflight_d = inflight_q - CNT_ONE;
        end
        FLUSH: begin
          if (imemRspValid && (drop_q != '0)) drop_d = drop_q - CNT_ONE;
          if (drop_d == '0) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (redirect) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_ONE;
      else if (pop && !push) fifo_cnt <= fifo_cnt - CNT_ONE;
    end
  end

  // Storage needs no reset: entries are only visible while fifo_cnt covers them.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{pc: rsp_pc_q, data: imemRspData};
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      fetchCount <= '0;
      flushCount <= '0;
    end else begin
      if (pop)      fetchCount <= fetchCount + 32'd1;
      if (redirect) flushCount <= flushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model, fetch scoreboard, vector table and redirect corners.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPc = '0;
  logic        imemReqValid;
  logic        imemReqReady = 1'b0;
  logic [31:0] imemReqAddr;
  logic        imemRspValid = 1'b0;
  logic [31:0] imemRspData = '0;
  logic        instrValid;
  logic        instrReady = 1'b0;
  logic [31:0] instrData;
  logic [31:0] instrPc;
`ifdef FETCH_STATS_EN
  logic [31:0] fetchCount, flushCount;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .RESET_PC(32'd0)) dut (
    .clk(clk), .rstN(rstN), .redirect(redirect), .redirectPc(redirectPc),
    .imemReqValid(imemReqValid), .imemReqReady(imemReqReady), .imemReqAddr(imemReqAddr),
    .imemRspValid(imemRspValid), .imemRspData(imemRspData),
    .instrValid(instrValid), .instrReady(instrReady), .instrData(instrData), .instrPc(instrPc)
`ifdef FETCH_STATS_EN
    , .fetchCount(fetchCount), .flushCount(flushCount)
`endif
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct {
    logic reqRdy; logic iRdy;
    logic reqValid; logic [31:0] addr; logic iValid; logic [31:0] pc; logic [31:0] data;
  } vec_t;

  mreq_t memq[$];
  exp_t  expq[$];
  vec_t  vecs[8];
  int    cyc, lat, nCmp, nErr, nReq, nPop, nRedir;
  logic [31:0] expAddr, prevAddr;
  bit    noValidNext, sawWrap, randLat;

  function automatic logic [31:0] memfn(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  // Advance one edge, then present the next due memory response (one per cycle, in order).
  task automatic to_next();
    @(posedge clk);
    #1;
    cyc++;
    if (memq.size() != 0 && memq[0].due <= cyc + 1) begin
      imemRspValid = 1'b1;
      imemRspData  = memfn(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      imemRspValid = 1'b0;
      imemRspData  = 32'hDEAD_DEAD;
    end
  endtask

  task automatic observe();
    bit rf, pf;
    rf = imemReqValid && imemReqReady;
    pf = instrValid && instrReady && !redirect;
    if (noValidNext) begin
      chk("valid_after_redirect", instrValid, 0);
      noValidNext = 0;
    end
    if (redirect) chk("no_req_on_redirect", imemReqValid, 0);
    if (instrValid) begin
      if (expq.size() == 0) chk("unexpected_instr_valid", instrValid, 0);
      else begin
        chk("instr_pc", instrPc, expq[0].pc);
        chk("instr_data", instrData, expq[0].data);
        if (pf) begin
          void'(expq.pop_front());
          nPop++;
        end
      end
    end
    if (rf) begin
      chk("req_addr", imemReqAddr, expAddr);
      if (prevAddr == 32'hFFFF_FFFC && imemReqAddr == 32'h0) sawWrap = 1;
      prevAddr = imemReqAddr;
      memq.push_back('{addr: imemReqAddr,
                       due: cyc + 1 + (randLat ? int'($urandom_range(1, 4)) : lat)});
      expq.push_back('{pc: expAddr, data: memfn(expAddr)});
      expAddr += 32'd4;
      nReq++;
    end
    if (redirect) begin
      expq.delete();
      expAddr = redirectPc & 32'hFFFF_FFFC;
      noValidNext = 1;
      nRedir++;
    end
  endtask

  task automatic cycle();
    to_neg();
    observe();
    to_next();
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    redirect = 1'b0;
    imemReqReady = 1'b1;
    instrReady = 1'b0;
    imemRspValid = 1'b0;
    memq.delete();
    expq.delete();
    expAddr = '0;
    prevAddr = '0;
    noValidNext = 0;
    nPop = 0;
    nRedir = 0;
    to_neg();
    chk("rst_req_valid", imemReqValid, 0);
    chk("rst_instr_valid", instrValid, 0);
    chk("rst_instr_data", instrData, 0);
    chk("rst_instr_pc", instrPc, 0);
    chk("rst_req_addr", imemReqAddr, 32'h0);
    @(posedge clk); #1; cyc++;
    @(posedge clk); #1; cyc++;
    rstN = 1'b1;
  endtask

  task automatic drain(string name);
    int i;
    imemReqReady = 1'b0;
    instrReady = 1'b1;
    for (i = 0; i < 200; i++) begin
      if (expq.size() == 0 && memq.size() == 0 && !imemRspValid) break;
      cycle();
    end
    chk({name, "_drain_done"}, (i < 200), 1);
    to_neg();
    chk({name, "_empty"}, instrValid, 0);
    observe();
    to_next();
  endtask

  task automatic wait_first(logic [31:0] pc, string name);
    bit found;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      to_neg();
      if (instrValid) begin
        chk(name, instrPc, pc);
        found = 1;
      end
      observe();
      to_next();
    end
    chk({name, "_seen"}, found, 1);
  endtask

  initial begin
    int n0;
    for (int k = 0; k < 8; k++) begin
      vecs[k].reqRdy   = 1'b1;
      vecs[k].iRdy     = 1'b1;
      vecs[k].reqValid = 1'b1;
      vecs[k].addr     = 32'(4 * k);
      vecs[k].iValid   = (k >= 2);
      vecs[k].pc       = (k >= 2) ? 32'(4 * (k - 2)) : 32'h0;
      vecs[k].data     = (k >= 2) ? memfn(32'(4 * (k - 2))) : 32'h0;
    end
    cyc = 0; nCmp = 0; nErr = 0; nReq = 0; lat = 1; randLat = 0; sawWrap = 0;

    // Streaming after reset with a 1-cycle memory.
    do_reset();
    lat = 1;
    for (int k = 0; k < 8; k++) begin
      imemReqReady = vecs[k].reqRdy;
      instrReady   = vecs[k].iRdy;
      to_neg();
      chk("vec_req_valid", imemReqValid, vecs[k].reqValid);
      chk("vec_req_addr", imemReqAddr, vecs[k].addr);
      chk("vec_instr_valid", instrValid, vecs[k].iValid);
      chk("vec_instr_pc", instrPc, vecs[k].pc);
      chk("vec_instr_data", instrData, vecs[k].data);
      observe();
      to_next();
    end
    drain("stream");

    // Decode stalled: credits cap outstanding work at FIFO_DEPTH.
    do_reset();
    lat = 1;
    instrReady = 1'b0;
    imemReqReady = 1'b1;
    n0 = nReq;
    run(12);
    chk("credit_req_count", nReq - n0, 4);
    to_neg();
    chk("full_req_valid", imemReqValid, 0);
    chk("full_instr_valid", instrValid, 1);
    chk("full_head_pc", instrPc, 32'h0);
    observe();
    to_next();
    drain("full");

    // Two reads in flight when redirected.
    do_reset();
    lat = 4;
    imemReqReady = 1'b1;
    instrReady = 1'b1;
    run(2);
    imemReqReady = 1'b0;
    redirect = 1'b1;
    redirectPc = 32'h100;
    cycle();
    redirect = 1'b0;
    imemReqReady = 1'b1;
    wait_first(32'h100, "inflight_redirect_pc");
    run(6);
    drain("inflight");

    // Redirect coinciding with a response; unaligned target.
    lat = 2;
    imemReqReady = 1'b1;
    instrReady = 1'b1;
    run(10);
    redirect = 1'b1;
    redirectPc = 32'h402;
    cycle();
    redirect = 1'b0;
    wait_first(32'h400, "rsp_redirect_pc");
    run(8);
    drain("rsp_redirect");

    // Back-to-back redirects while flushing.
    lat = 4;
    imemReqReady = 1'b1;
    run(8);
    redirect = 1'b1;
    redirectPc = 32'h200;
    cycle();
    redirectPc = 32'h300;
    cycle();
    redirect = 1'b0;
    wait_first(32'h300, "double_redirect_pc");
    run(8);
    drain("double_redirect");

    // PC wrap at the top of the address space.
    lat = 1;
    imemReqReady = 1'b1;
    redirect = 1'b1;
    redirectPc = 32'hFFFF_FFF4;
    cycle();
    redirect = 1'b0;
    wait_first(32'hFFFF_FFF4, "wrap_first_pc");
    run(8);
    chk("addr_wrap", sawWrap, 1);
    drain("wrap");

    // Random backpressure, latency and redirects.
    randLat = 1;
    for (int i = 0; i < 400; i++) begin
      imemReqReady = ($urandom_range(0, 3) != 0);
      instrReady   = ($urandom_range(0, 3) != 0);
      redirect     = ($urandom_range(0, 29) == 0);
      redirectPc   = $urandom & 32'h0000_FFFF;
      cycle();
    end
    redirect = 1'b0;
    randLat = 0;
    drain("random");

`ifdef FETCH_STATS_EN
    to_neg();
    chk("stats_fetch_count", fetchCount, nPop);
    chk("stats_flush_count", flushCount, nRedir);
    observe();
    to_next();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end
endmodule
